// File: rtl/i2s_shift_in_if.sv
// FIFO-side bus of the I2S capture deserializer: stereo pair, write strobe,
// back-pressure and sticky overrun status.
interface i2s_shift_in_if;
  localparam int unsigned WORD_W = 32;

  logic              fifo_ready;
  logic [WORD_W-1:0] fifo_left_data;
  logic [WORD_W-1:0] fifo_right_data;
  logic              fifo_write;
  logic              overrun;

  modport master (
    input  fifo_ready,
    output fifo_left_data,
    output fifo_right_data,
    output fifo_write,
    output overrun
  );

  modport slave (
    output fifo_ready,
    input  fifo_left_data,
    input  fifo_right_data,
    input  fifo_write,
    input  overrun
  );
endinterface

// File: rtl/i2s_shift_in.sv
// I2S receive deserializer: assembles left-justified 32-bit left/right words
// from the ADC serial stream and writes each complete stereo pair to the FIFO.
module i2s_shift_in (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           bclk,
  input  logic           lrclk,
  input  logic           data_in,
  i2s_shift_in_if.master fifo
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned IDX_W  = 5;

  logic              bclk_d;
  logic              lrclk_d;
  logic [WORD_W-1:0] cap;
  logic [WORD_W-1:0] cap_nxt;
  logic [WORD_W-1:0] cap_final;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              pending;
  logic              pending_nxt;
  logic              ch;
  logic              ch_nxt;
  logic              word_valid;
  logic              word_valid_nxt;
  logic              left_valid;
  logic              left_valid_nxt;
  logic [WORD_W-1:0] left_nxt;
  logic [WORD_W-1:0] right_nxt;
  logic              write_nxt;
  logic              overrun_nxt;
  logic              bclk_rise;
  logic              lr_edge;
  logic              slot_arm;
  logic              slot_ch;
  logic              slot_valid;
  logic              cnt_full;
  logic [IDX_W-1:0]  bit_idx;

  // Next-state: an lrclk edge in this cycle is folded in before the bclk rise,
  // so a coincident rise acts as the delay slot for that edge.
  always_comb begin
    bclk_rise      = bclk & ~bclk_d;
    lr_edge        = lrclk ^ lrclk_d;
    cnt_full       = (cnt >= CNT_W'(WORD_W));
    bit_idx        = IDX_W'(WORD_W - 1) - cnt[IDX_W-1:0];
    slot_arm       = pending | lr_edge;
    slot_ch        = lr_edge ? lrclk_d : ch;
    slot_valid     = word_valid & ~(lr_edge & pending);

    cap_final      = cap;
    if (!cnt_full) begin
      cap_final[bit_idx] = data_in;
    end

    cap_nxt        = cap;
    cnt_nxt        = cnt;
    pending_nxt    = pending;
    ch_nxt         = ch;
    word_valid_nxt = word_valid;
    left_valid_nxt = left_valid;
    left_nxt       = fifo.fifo_left_data;
    right_nxt      = fifo.fifo_right_data;
    write_nxt      = 1'b0;
    overrun_nxt    = fifo.overrun;

    if (!enable) begin
      cap_nxt        = '0;
      cnt_nxt        = '0;
      pending_nxt    = 1'b0;
      word_valid_nxt = 1'b0;
      left_valid_nxt = 1'b0;
      overrun_nxt    = 1'b0;
    end else begin
      pending_nxt    = slot_arm;
      ch_nxt         = slot_ch;
      word_valid_nxt = slot_valid;

      if (bclk_rise) begin
        if (slot_arm) begin
          if (!slot_ch) begin
            left_nxt       = cap_final;
            left_valid_nxt = slot_valid;
          end else begin
            right_nxt      = cap_final;
            if (slot_valid && left_valid) begin
              if (fifo.fifo_ready) begin
                write_nxt   = 1'b1;
              end else begin
                overrun_nxt = 1'b1;
              end
            end
            left_valid_nxt = 1'b0;
          end
          cap_nxt        = '0;
          cnt_nxt        = '0;
          pending_nxt    = 1'b0;
          word_valid_nxt = 1'b1;
        end else begin
          cap_nxt = cap_final;
          if (!cnt_full) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_d               <= 1'b0;
      lrclk_d              <= 1'b0;
      cap                  <= '0;
      cnt                  <= '0;
      pending              <= 1'b0;
      ch                   <= 1'b0;
      word_valid           <= 1'b0;
      left_valid           <= 1'b0;
      fifo.fifo_left_data  <= '0;
      fifo.fifo_right_data <= '0;
      fifo.fifo_write      <= 1'b0;
      fifo.overrun         <= 1'b0;
    end else begin
      bclk_d               <= bclk;
      lrclk_d              <= lrclk;
      cap                  <= cap_nxt;
      cnt                  <= cnt_nxt;
      pending              <= pending_nxt;
      ch                   <= ch_nxt;
      word_valid           <= word_valid_nxt;
      left_valid           <= left_valid_nxt;
      fifo.fifo_left_data  <= left_nxt;
      fifo.fifo_right_data <= right_nxt;
      fifo.fifo_write      <= write_nxt;
      fifo.overrun         <= overrun_nxt;
    end
  end
endmodule

// File: tb/tb_i2s_shift_in.sv
// Directed bench for i2s_shift_in: drives an I2S stream (4 clk per bclk) and
// checks FIFO writes, data, latency, overrun, enable and reset behaviour.
module tb_i2s_shift_in;
  localparam int EV_NONE   = 0;
  localparam int EV_EN_OFF = 1;
  localparam int EV_EN_ON  = 2;
  localparam int EV_RESET  = 3;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic bclk;
  logic lrclk;
  logic data_in;

  i2s_shift_in_if bus ();

  i2s_shift_in dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .bclk    (bclk),
    .lrclk   (lrclk),
    .data_in (data_in),
    .fifo    (bus)
  );

  always #5 clk = ~clk;

  int          total    = 0;
  int          bad      = 0;
  int          cyc      = 0;
  int          wr_cnt   = 0;
  int          wr_cyc   = 0;
  int          dbl      = 0;
  int          slot_cyc = 0;
  logic [31:0] wr_left  = '0;
  logic [31:0] wr_right = '0;
  logic        prev_wr  = 1'b0;
  logic        carry    = 1'b0;
  logic [31:0] snap_l   = '1;
  logic [31:0] snap_r   = '1;
  logic        snap_w   = 1'b1;
  logic        snap_o   = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (bus.fifo_write === 1'b1) begin
      wr_cnt   = wr_cnt + 1;
      wr_left  = bus.fifo_left_data;
      wr_right = bus.fifo_right_data;
      wr_cyc   = cyc;
      if (prev_wr) dbl = dbl + 1;
    end
    prev_wr = (bus.fifo_write === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One I2S word: first bclk period carries the previous word's LSB (delay slot),
  // then bits n-1..1 of this word; bit 0 rides in the next word's first period.
  task automatic send_word(input logic lr, input logic [63:0] w, input int n,
                           input int ev_at, input int ev);
    for (int i = 0; i < n; i++) begin
      logic d;
      d       = (i == 0) ? carry : w[n - i];
      bclk    = 1'b0;
      lrclk   = lr;
      data_in = d;
      if (i == ev_at) begin
        case (ev)
          EV_EN_OFF: enable = 1'b0;
          EV_EN_ON:  enable = 1'b1;
          EV_RESET:  reset  = 1'b1;
          default:   ;
        endcase
      end
      @(negedge clk);
      if (i == ev_at && ev == EV_RESET) begin
        snap_l = bus.fifo_left_data;
        snap_r = bus.fifo_right_data;
        snap_w = bus.fifo_write;
        snap_o = bus.overrun;
        reset  = 1'b0;
      end
      @(negedge clk);
      bclk = 1'b1;
      if (i == 0) slot_cyc = cyc;
      repeat (2) @(negedge clk);
    end
    carry = w[0];
  endtask

  task automatic sw(input logic lr, input logic [63:0] w, input int n);
    send_word(lr, w, n, -1, EV_NONE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; bclk = 1'b0; lrclk = 1'b0; data_in = 1'b0;
    bus.fifo_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_left",    bus.fifo_left_data,  32'h0);
    check("rst_right",   bus.fifo_right_data, 32'h0);
    check("rst_write",   32'(bus.fifo_write), 32'h0);
    check("rst_overrun", 32'(bus.overrun),    32'h0);
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clk);

    // 32-bit words; the first pair after enable is partial and dropped.
    sw(1'b0, 64'h0, 32);
    sw(1'b1, 64'h0, 32);
    sw(1'b0, 64'hA5A50001, 32);
    check("warmup_nowrite", 32'(wr_cnt), 32'd0);
    sw(1'b1, 64'h12345678, 32);
    sw(1'b0, 64'hABCDEF, 24);
    check("w32_count",   32'(wr_cnt), 32'd1);
    check("w32_left",    wr_left,  32'hA5A50001);
    check("w32_right",   wr_right, 32'h12345678);
    check("w32_latency", 32'(wr_cyc - slot_cyc), 32'd1);

    // 24-bit words, left-justified.
    sw(1'b1, 64'h000001, 24);
    sw(1'b0, 64'h00FFFFFFFF00, 40);
    check("w24_count", 32'(wr_cnt), 32'd2);
    check("w24_left",  wr_left,  32'hABCDEF00);
    check("w24_right", wr_right, 32'h00000100);

    // 40-bit words, truncated to the first 32 bits.
    sw(1'b1, 64'h123456789A, 40);
    sw(1'b0, 64'h11111111, 32);
    check("w40_count", 32'(wr_cnt), 32'd3);
    check("w40_left",  wr_left,  32'hFFFFFFFF);
    check("w40_right", wr_right, 32'h12345678);

    // FIFO full across a right-word completion.
    bus.fifo_ready = 1'b0;
    sw(1'b1, 64'h22222222, 32);
    sw(1'b0, 64'h33333333, 32);
    bus.fifo_ready = 1'b1;
    check("ovr_nowrite", 32'(wr_cnt), 32'd3);
    check("ovr_set",     32'(bus.overrun), 32'd1);
    check("ovr_left",    bus.fifo_left_data,  32'h11111111);
    check("ovr_right",   bus.fifo_right_data, 32'h22222222);
    sw(1'b1, 64'h44444444, 32);
    sw(1'b0, 64'h55555555, 32);
    check("ovr_next_count", 32'(wr_cnt), 32'd4);
    check("ovr_next_left",  wr_left,  32'h33333333);
    check("ovr_next_right", wr_right, 32'h44444444);
    check("ovr_sticky",     32'(bus.overrun), 32'd1);

    // Enable dropped mid-left word.
    sw(1'b1, 64'h66666666, 32);
    send_word(1'b0, 64'h77777777, 32, 10, EV_EN_OFF);
    check("dis_count",   32'(wr_cnt), 32'd5);
    check("dis_wleft",   wr_left,  32'h55555555);
    check("dis_wright",  wr_right, 32'h66666666);
    check("dis_overrun", 32'(bus.overrun),    32'd0);
    check("dis_write",   32'(bus.fifo_write), 32'd0);
    check("dis_hold_l",  bus.fifo_left_data,  32'h55555555);
    check("dis_hold_r",  bus.fifo_right_data, 32'h66666666);

    // Enable raised mid-right word.
    send_word(1'b1, 64'h88888888, 32, 10, EV_EN_ON);
    sw(1'b0, 64'h99999999, 32);
    sw(1'b1, 64'hAAAAAAAA, 32);
    check("en_partial_nowrite", 32'(wr_cnt), 32'd5);
    sw(1'b0, 64'hBBBBBBBB, 32);
    check("en_count", 32'(wr_cnt), 32'd6);
    check("en_left",  wr_left,  32'h99999999);
    check("en_right", wr_right, 32'hAAAAAAAA);

    // One-cycle reset mid-right word.
    send_word(1'b1, 64'hCCCCCCCC, 32, 10, EV_RESET);
    check("mrst_left",    snap_l,       32'h0);
    check("mrst_right",   snap_r,       32'h0);
    check("mrst_write",   32'(snap_w),  32'h0);
    check("mrst_overrun", 32'(snap_o),  32'h0);
    sw(1'b0, 64'hDDDDDDDD, 32);
    check("mrst_nowrite", 32'(wr_cnt), 32'd6);
    sw(1'b1, 64'hEEEEEEEE, 32);
    sw(1'b0, 64'h0, 32);
    check("mrst_count",   32'(wr_cnt), 32'd7);
    check("mrst_wleft",   wr_left,  32'hDDDDDDDD);
    check("mrst_wright",  wr_right, 32'hEEEEEEEE);
    check("mrst_latency", 32'(wr_cyc - slot_cyc), 32'd1);

    check("no_back_to_back", 32'(dbl), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2s_shift_in.md
# i2s_shift_in

I2S receive deserializer for the ADC path, the capture-side counterpart of the playback shifter. It samples the serial ADC data on `bclk` edges detected in the `clk` domain and honours the I2S one-`bclk` delay after each `lrclk` edge. It assembles left-justified 32-bit left/right words and pushes each complete stereo pair into a dual-clock capture FIFO with a single write strobe. It sits between the codec pins (`bclk`/`lrclk` already synchronous to `clk`) and the FIFO feeding the DMA/Avalon side.

## Interface
- No parameters. Word width is fixed at 32 bits; shorter words are left-justified, longer words are truncated.
- `clk` in 1: master clock, synchronous with `bclk`/`lrclk`.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: software enable.
- `bclk` in 1: I2S bit clock.
- `lrclk` in 1: I2S word clock; low = left, high = right.
- `data_in` in 1: serial data from the ADC.
- `fifo_ready` in 1: FIFO can accept a write (not full).
- `fifo_left_data` out 32: left sample, left-justified.
- `fifo_right_data` out 32: right sample, left-justified.
- `fifo_write` out 1: one-`clk` write strobe; data is valid in the same cycle.
- `overrun` out 1: sticky flag, set when a pair is dropped because `fifo_ready` was low.

## Operation
- Edge detect: `bclk_d` and `lrclk_d` are registered copies. `bclk_rise = bclk & ~bclk_d`. `lr_edge = lrclk ^ lrclk_d`.
- Word assembly: a 32-bit capture register `cap` and a 6-bit bit counter `cnt`, saturating at 32. On each `bclk_rise` while a word is active, `data_in` is written to `cap[31-cnt]` if `cnt<32`, and `cnt` increments. Bits past 32 are ignored. Unwritten LSBs stay 0.
- Delay slot: an `lr_edge` sets `pending` and latches the ending channel `ch = lrclk_d`. The next `bclk_rise` is the delay slot. Its bit is stored as the last bit of the ending word, that word completes, and then `cap` and `cnt` clear and the new word starts.
- Completion of ch=0 (left): `fifo_left_data <= cap_final`, `left_valid <= word_valid`.
- Completion of ch=1 (right): `fifo_right_data <= cap_final`. If `word_valid & left_valid`: assert `fifo_write` when `fifo_ready`, otherwise set `overrun`. Then clear `left_valid`.
- `word_valid`: set only for a word whose starting `lr_edge` was observed while enabled. A partial first word after enable or reset is discarded.
- If a second `lr_edge` arrives while `pending` is set, the pending word is discarded (`word_valid` cleared) and `pending` re-arms for the new edge.
- If `lr_edge` and `bclk_rise` occur in the same `clk` cycle, the edge is registered first, and that `bclk_rise` is treated as the delay slot.
- `enable` low: `cap`, `cnt`, `pending`, `word_valid`, `left_valid` and `overrun` clear. `fifo_write` is held 0. Data outputs hold their last value.

## Timing
- Reset values: `fifo_left_data`=0, `fifo_right_data`=0, `fifo_write`=0, `overrun`=0. All internal state is 0.
- Reset takes effect at the next `clk` edge. A reset mid-word drops the word and any pending pair, and no write is issued afterwards.
- Completion cycle C is the `clk` cycle in which the delay-slot `bclk_rise` is seen. The data output registers update at the end of C.
- `fifo_write` is high for exactly cycle C+1 and `fifo_right_data`/`fifo_left_data` are stable in C+1.
- The FIFO ready check uses `fifo_ready` sampled in cycle C.
- At most one `fifo_write` per `lrclk` period. `fifo_write` is never high for two consecutive cycles.
- `overrun` rises in C+1 and remains high until `reset` or `enable` goes low.
- Input requirement: `clk` is at least 4x `bclk`, so every `bclk` level lasts at least 2 `clk` cycles.

## Test plan
- 64 `bclk`/frame, `enable`=1, `fifo_ready`=1, left=0xA5A50001, right=0x12345678 -> one `fifo_write` pulse with exactly those values, one `clk` after the delay slot following the `lrclk` falling edge.
- 48 `bclk`/frame (24-bit words), left=0xABCDEF, right=0x000001 -> write with left=0xABCDEF00, right=0x00000100.
- 80 `bclk`/frame (40-bit words), left=0xFFFFFFFF followed by 8 zero bits -> left=0xFFFFFFFF, extra bits ignored.
- `fifo_ready`=0 across one right-word completion -> no `fifo_write`, `overrun`=1 persists through later good pairs, and clears when `enable` drops to 0.
- `enable` raised mid-right word -> no write for that frame, first write carries the next full left/right pair. `enable` dropped mid-left word -> no write.
- `reset` pulsed for 1 cycle mid-right word -> all outputs 0 next cycle, no write for that frame, normal writes from the next complete pair.
